// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared button indices, clock rate and auto-repeat state encodings
package game_pkg;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    localparam int CLK_HZ = 100_000_000;

    localparam logic [1:0] RPT_IDLE   = 2'd0;
    localparam logic [1:0] RPT_DELAY  = 2'd1;
    localparam logic [1:0] RPT_REPEAT = 2'd2;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-FF synchronizer, counter debounce, press pulse and auto-repeat
module btn_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             REPEAT_EN   = (REPEAT_DELAY > 0);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;
    logic             pressed_s, rise, fall;

    assign pressed_s = ~s2_q;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (pressed_s != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = pressed_s;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    // A debounced release always wins over a repeat pulse due in the same cycle.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        if (fall) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
        end else if (rise) begin
            pulse_d   = 1'b1;
            rpt_cnt_d = '0;
            state_d   = REPEAT_EN ? RPT_DELAY : RPT_IDLE;
        end else begin
            case (state_q)
                RPT_DELAY, RPT_REPEAT: begin
                    if (rpt_cnt_q == ((state_q == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = RPT_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = RPT_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= RPT_IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            s1_q      <= raw_n;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - conditions the four active-low game buttons feeding VGADemo
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000,
    parameter int CNT_W           = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic [3:0] btn_held
);

    logic [3:0] raw_n;
    logic [3:0] pulse;

    assign raw_n[BTN_UP]    = up;
    assign raw_n[BTN_DOWN]  = down;
    assign raw_n[BTN_LEFT]  = left;
    assign raw_n[BTN_RIGHT] = right;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw_n(raw_n[i]),
            .pulse(pulse[i]),
            .held (btn_held[i])
        );
    end

    assign up_pulse    = pulse[BTN_UP];
    assign down_pulse  = pulse[BTN_DOWN];
    assign left_pulse  = pulse[BTN_LEFT];
    assign right_pulse = pulse[BTN_RIGHT];

endmodule
